// File: rtl/blankport_stim_sig.sv
// ---------------------------------------------------------------------------
// blankport_stim_sig
//
// Stimulus and response-capture stage for the blank-port test module.
// A start pulse launches a run of NVEC vectors: the vector count drives the
// DUT's a/b inputs, and each returned o value is folded into a 16-bit LFSR
// signature, so the bench only has to compare one word per run.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (aborts any run in progress)
//   start    begins a run; only looked at in IDLE or DONE
//   a_out    registered stimulus to DUT a (vector bits [3:0])
//   b_out    registered stimulus to DUT b (vector bits [7:4])
//   o_in     DUT o, a combinational function of a_out/b_out
//   busy     high while vectors are driven or the last response drains
//   done     high once the run has finished; sig is then stable
//   sig      current signature
//   vec_cnt  number of o values absorbed into sig
// ---------------------------------------------------------------------------
module blankport_stim_sig #(
  parameter int NVEC = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  a_out,
  output logic [3:0]  b_out,
  input  logic [7:0]  o_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig,
  output logic [8:0]  vec_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam logic [8:0] LAST = 9'(NVEC - 1);

  state_t      state_reg, state_next;
  logic [8:0]  cnt_reg;
  logic [7:0]  vec_reg;
  logic [7:0]  o_q_reg;
  logic        cap_valid_reg;
  logic [15:0] sig_reg;
  logic [8:0]  vec_cnt_reg;

  // One LFSR step with the captured response XORed into the low byte.
  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [7:0] d);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ {8'h00, d};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   if (cnt_reg == LAST) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (start) state_next = DRIVE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      DRIVE, DRAIN: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      ;
    endcase
  end

  // Datapath: vector counter, response capture and signature.
  // The response to a vector is registered one cycle before it is folded,
  // so the last response is absorbed in the single DRAIN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      vec_reg       <= '0;
      o_q_reg       <= '0;
      cap_valid_reg <= 1'b0;
      sig_reg       <= '0;
      vec_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            cnt_reg       <= '0;
            vec_reg       <= '0;
            sig_reg       <= '0;
            vec_cnt_reg   <= '0;
            cap_valid_reg <= 1'b0;
          end
        end
        DRIVE: begin
          o_q_reg       <= o_in;
          cap_valid_reg <= 1'b1;
          if (cap_valid_reg) begin
            sig_reg     <= sig_step(sig_reg, o_q_reg);
            vec_cnt_reg <= vec_cnt_reg + 9'd1;
          end
          // The last vector stays on a_out/b_out through DRAIN.
          if (cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + 9'd1;
            vec_reg <= 8'(cnt_reg + 9'd1);
          end
        end
        DRAIN: begin
          sig_reg       <= sig_step(sig_reg, o_q_reg);
          vec_cnt_reg   <= vec_cnt_reg + 9'd1;
          cap_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign a_out   = vec_reg[3:0];
  assign b_out   = vec_reg[7:4];
  assign sig     = sig_reg;
  assign vec_cnt = vec_cnt_reg;

endmodule

// File: tb/tb_blankport_stim_sig.sv
// ---------------------------------------------------------------------------
// tb_blankport_stim_sig
//
// Four instances share clk/reset/start:
//   u256: NVEC=256, o_in is either {b,a} loopback or a random lookup table
//   u4:   NVEC=4,  o_in tied 8'h00
//   u1:   NVEC=1,  o_in tied 8'h01
//   u2:   NVEC=2,  o_in tied 8'h01
// Runs on u256 are predicted by a reference model when started and queued;
// a monitor pops the prediction whenever done rises and checks the result
// together with the vector sequence seen during busy.
// ---------------------------------------------------------------------------
module tb_blankport_stim_sig;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start;
  logic mode;
  logic [7:0] tbl [256];

  logic [3:0]  a256, b256, a4, b4, a1, b1, a2, b2;
  logic [7:0]  o256;
  logic        busy256, done256, busy4, done4, busy1, done1, busy2, done2;
  logic [15:0] sig256, sig4, sig1, sig2;
  logic [8:0]  vc256, vc4, vc1, vc2;

  assign o256 = mode ? tbl[{b256, a256}] : {b256, a256};

  blankport_stim_sig #(.NVEC(256)) u256 (
    .clk(clk), .reset(reset), .start(start), .a_out(a256), .b_out(b256),
    .o_in(o256), .busy(busy256), .done(done256), .sig(sig256), .vec_cnt(vc256));
  blankport_stim_sig #(.NVEC(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .a_out(a4), .b_out(b4),
    .o_in(8'h00), .busy(busy4), .done(done4), .sig(sig4), .vec_cnt(vc4));
  blankport_stim_sig #(.NVEC(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .a_out(a1), .b_out(b1),
    .o_in(8'h01), .busy(busy1), .done(done1), .sig(sig1), .vec_cnt(vc1));
  blankport_stim_sig #(.NVEC(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .a_out(a2), .b_out(b2),
    .o_in(8'h01), .busy(busy2), .done(done2), .sig(sig2), .vec_cnt(vc2));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] sig;
    int          n;
  } exp_t;
  exp_t sb[$];
  logic [7:0] obs[$];
  logic done_prev = 1'b0;
  logic [15:0] last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signature over the response to every vector 0..n-1 in order.
  function automatic logic [15:0] ref_sig(input int n);
    logic [15:0] s;
    logic [7:0]  d;
    s = 16'h0000;
    for (int k = 0; k < n; k++) begin
      d = mode ? tbl[k] : 8'(k);
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {8'h00, d};
    end
    return s;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.sig = ref_sig(256);
    e.n   = 256;
    last_exp = e.sig;
    sb.push_back(e);
    $display("issue run: mode=%0d expected sig=0x%04h", mode, e.sig);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    push_exp();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done256) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got done=0 after %0d cycles, want done=1", limit);
  endtask

  // Monitor / scoreboard for u256.
  initial begin
    exp_t e;
    int bad;
    forever begin
      @(negedge clk);
      if (!busy256 && !done256) obs.delete();
      if (busy256) obs.push_back({b256, a256});
      if (done256 && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard, want no done");
        end else begin
          e = sb.pop_front();
          bad = 0;
          for (int k = 0; k < obs.size(); k++)
            if (obs[k] !== ((k < e.n) ? 8'(k) : 8'(e.n - 1))) bad++;
          chk("run_sig", {16'h0, sig256}, {16'h0, e.sig});
          chk("run_vec_cnt", {23'h0, vc256}, e.n);
          chk("run_busy_cycles", obs.size(), e.n + 1);
          chk("run_vector_seq_errors", bad, 0);
          $display("run done: sig=0x%04h vec_cnt=%0d busy_cycles=%0d", sig256, vc256, obs.size());
        end
        obs.delete();
      end
      done_prev = done256;
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("reset_a", {28'h0, a256}, 0);
    chk("reset_b", {28'h0, b256}, 0);
    chk("reset_sig", {16'h0, sig256}, 0);
    chk("reset_vec_cnt", {23'h0, vc256}, 0);
    chk("reset_busy", {31'h0, busy256}, 0);
    chk("reset_done", {31'h0, done256}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start_busy", {31'h0, busy256}, 0);

    // Loopback run; small instances are checked cycle by cycle meanwhile.
    pulse_start();
    for (int j = 0; j < 7; j++) begin
      if (j <= 4) chk($sformatf("u4_vec_j%0d", j), {24'h0, b4, a4}, (j < 4) ? j : 3);
      chk($sformatf("u4_busy_j%0d", j), {31'h0, busy4}, (j < 5) ? 1 : 0);
      chk($sformatf("u4_done_j%0d", j), {31'h0, done4}, (j >= 5) ? 1 : 0);
      chk($sformatf("u1_done_j%0d", j), {31'h0, done1}, (j >= 2) ? 1 : 0);
      chk($sformatf("u2_done_j%0d", j), {31'h0, done2}, (j >= 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("u4_sig", {16'h0, sig4}, 32'h0000);
    chk("u4_vec_cnt", {23'h0, vc4}, 4);
    chk("u1_sig", {16'h0, sig1}, 32'h0001);
    chk("u1_vec_cnt", {23'h0, vc1}, 1);
    chk("u2_sig", {16'h0, sig2}, 32'h0003);
    chk("u2_vec_cnt", {23'h0, vc2}, 2);
    wait_done(400);

    // Random-response runs with random idle gaps.
    mode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse_start();
      wait_done(400);
      repeat (4) @(negedge clk);
      chk($sformatf("done_hold_sig_r%0d", r), {16'h0, sig256}, {16'h0, last_exp});
      chk($sformatf("done_hold_done_r%0d", r), {31'h0, done256}, 1);
    end

    // Abort with reset at cycle 3, then a full run.
    mode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_a", {28'h0, a256}, 0);
    chk("abort_b", {28'h0, b256}, 0);
    chk("abort_sig", {16'h0, sig256}, 0);
    chk("abort_vec_cnt", {23'h0, vc256}, 0);
    chk("abort_busy", {31'h0, busy256}, 0);
    chk("abort_done", {31'h0, done256}, 0);
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", {31'h0, busy256}, 0);
    pulse_start();
    wait_done(400);

    // start held high: DRIVE/DRAIN ignore it, DONE restarts immediately.
    @(negedge clk);
    start = 1'b1;
    push_exp();
    wait_done(400);
    push_exp();
    @(negedge clk);
    chk("held_done_one_cycle", {31'h0, done256}, 0);
    chk("held_restart_busy", {31'h0, busy256}, 1);
    start = 1'b0;
    wait_done(400);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blankport_stim_sig.md
Name: blankport_stim_sig

Overview:
- Self-checking stimulus and response-capture stage wrapped around the blank-port test module.
- Drives its 4-bit `a`/`b` inputs from a counter-generated vector sequence and captures its 8-bit `o` output.
- Compresses the captured `o` values into a 16-bit LFSR signature, so the systest bench compares one word instead of a full trace.
- Sits directly upstream (stimulus) and downstream (capture) of the device under test in the systest harness.

Parameters:
- NVEC, 256, number of vectors driven per run; legal range 1..256.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse to begin a run; sampled only in IDLE or DONE.
- a_out  output  4  registered stimulus to DUT `a` = vec[3:0].
- b_out  output  4  registered stimulus to DUT `b` = vec[7:4].
- o_in  input  8  DUT `o`; combinational function of a_out/b_out.
- busy  output  1  high in DRIVE and DRAIN.
- done  output  1  high in DONE.
- sig  output  16  current signature.
- vec_cnt  output  9  number of o values absorbed into sig.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE; a_out=0, b_out=0, sig=0, vec_cnt=0, busy=0, done=0; internal cnt=0, o_q=0, cap_valid=0.
- Reset mid-run: aborts the run and applies the same values. No partial signature survives.
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE, or DONE with start=1: cnt<=0, a_out<=0, b_out<=0, sig<=0, vec_cnt<=0, cap_valid<=0, state<=DRIVE.
- DONE with start=0: hold state and all outputs.
- start is ignored in DRIVE and DRAIN.
- DRIVE, every edge:
  - o_q<=o_in; cap_valid<=1.
  - If cap_valid: sig<=F(sig,o_q); vec_cnt<=vec_cnt+1.
  - If cnt==NVEC-1: state<=DRAIN; a_out/b_out hold.
  - Else: cnt<=cnt+1; {b_out,a_out}<=(cnt+1)[7:0].
- DRAIN, one cycle: sig<=F(sig,o_q); vec_cnt<=vec_cnt+1; cap_valid<=0; state<=DONE.
- Signature function F(s,d):
  - fb = s[15]^s[13]^s[12]^s[10].
  - F = {s[14:0],fb} ^ {8'h00,d}.
- Widths and counts:
  - cnt is 9 bits; the vector value is cnt[7:0].
  - With NVEC=256, cnt reaches 255 and no wrap occurs.
  - vec_cnt equals NVEC in DONE.
- Latency:
  - The edge that samples start is E0. The DUT sees vector k during the cycle after edge E0+k.
  - o for vector k is captured into o_q at edge E0+k+1 and folded into sig at edge E0+k+2.
  - done rises at edge E0+NVEC+1, i.e. NVEC+1 cycles after the start edge.
- Outputs:
  - busy and done are decoded directly from state.
  - sig is stable throughout DONE until the next start or reset.
- Simultaneous events:
  - reset dominates start.
  - start in DONE restarts immediately; done drops on the same edge that enters DRIVE.

Test Plan:
- NVEC=4, o_in tied 8'h00, start pulse:
  - a_out/b_out step through vectors 0,1,2,3.
  - busy high for exactly 5 cycles; done rises at E0+5.
  - Required result: sig=0x0000, vec_cnt=4.
- NVEC=1, o_in tied 8'h01: required result sig=0x0001, vec_cnt=1, done at E0+2.
- NVEC=2, o_in tied 8'h01: required result sig=0x0003.
- NVEC=256, o_in={b_out,a_out} loopback:
  - a_out/b_out cover 0x00..0xFF in order with no wrap.
  - Required result: vec_cnt=256; sig matches the bench reference model of F.
- Abort and restart:
  - reset asserted at cycle 3 of a run: all outputs 0 and state IDLE on the next edge.
  - A later start completes with a sig identical to an uninterrupted run.
- start held high through a whole run:
  - Pulses in DRIVE/DRAIN are ignored.
  - On entering DONE with start still high, a second run begins on the next edge; done is high for exactly 1 cycle.
